// File: rtl/map_access_arbiter.sv
// Arbitrates the single-port tile-map RAM between the video prefetcher and game logic.
// Video has priority, but a game request that has waited GM_MAX_WAIT cycles wins once.
module map_access_arbiter #(
   parameter int          MAP_W       = 28,
   parameter int          MAP_H       = 31,
   parameter int          TXW         = 5,
   parameter int          TYW         = 5,
   parameter int          AW          = 10,
   parameter logic [3:0]  OOR_CODE    = 4'hF,
   parameter int          GM_MAX_WAIT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vid_req,
   input  logic [TXW-1:0] vid_tx,
   input  logic [TYW-1:0] vid_ty,
   output logic           vid_gnt,
   output logic           vid_valid,
   output logic [3:0]     vid_code,
   input  logic           gm_req,
   input  logic           gm_we,
   input  logic [TXW-1:0] gm_tx,
   input  logic [TYW-1:0] gm_ty,
   input  logic [3:0]     gm_wdata,
   output logic           gm_gnt,
   output logic           gm_rvalid,
   output logic [3:0]     gm_rdata,
   output logic           ram_en,
   output logic           ram_we,
   output logic [AW-1:0]  ram_addr,
   output logic [3:0]     ram_wdata,
   input  logic [3:0]     ram_rdata
);

   localparam int             WCW     = $clog2(GM_MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(GM_MAX_WAIT);
   localparam logic [TXW-1:0] TX_LIM  = TXW'(MAP_W);
   localparam logic [TYW-1:0] TY_LIM  = TYW'(MAP_H);
   localparam logic [AW-1:0]  ROW_LEN = AW'(MAP_W);

   logic [WCW-1:0] wait_q, wait_d;
   logic           gm_wins;
   logic [TXW-1:0] win_tx;
   logic [TYW-1:0] win_ty;
   logic           win_we;
   logic [3:0]     win_wdata;
   logic           win_oor;
   logic [AW-1:0]  win_addr;
   logic           any_gnt;
   logic           access;
   logic           rd_tag;

   // Pipeline tags: stage 1 lines up with the RAM strobe, stage 2 with ram_rdata.
   logic s1_vld_q, s1_gm_q, s1_oor_q;
   logic s2_vld_q, s2_gm_q, s2_oor_q;

   logic          ram_en_q, ram_we_q;
   logic [AW-1:0] ram_addr_q;
   logic [3:0]    ram_wdata_q;
   logic          vid_valid_q, gm_rvalid_q;
   logic [3:0]    vid_code_q, gm_rdata_q;

   assign gm_wins = gm_req && (!vid_req || (wait_q == WAIT_MAX));

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      gm_gnt    = 1'b0;
      vid_gnt   = 1'b0;
      win_tx    = vid_tx;
      win_ty    = vid_ty;
      win_we    = 1'b0;
      win_wdata = gm_wdata;
      if (!rst) begin
         gm_gnt  = gm_wins;
         vid_gnt = vid_req && !gm_wins;
      end
      if (gm_gnt) begin
         win_tx = gm_tx;
         win_ty = gm_ty;
         win_we = gm_we;
      end
      win_oor  = (win_tx >= TX_LIM) || (win_ty >= TY_LIM);
      win_addr = AW'(win_ty) * ROW_LEN + AW'(win_tx);
      any_gnt  = vid_gnt || gm_gnt;
      access   = any_gnt && !win_oor;
      rd_tag   = any_gnt && !win_we;

      wait_d = wait_q;
      if (!gm_req || gm_gnt) begin
         wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q      <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         s1_vld_q    <= 1'b0;
         s1_gm_q     <= 1'b0;
         s1_oor_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s2_gm_q     <= 1'b0;
         s2_oor_q    <= 1'b0;
         vid_valid_q <= 1'b0;
         vid_code_q  <= '0;
         gm_rvalid_q <= 1'b0;
         gm_rdata_q  <= '0;
      end else begin
         wait_q   <= wait_d;
         ram_en_q <= access;
         ram_we_q <= access && win_we;
         if (access) begin
            ram_addr_q  <= win_addr;
            ram_wdata_q <= win_wdata;
         end
         s1_vld_q <= rd_tag;
         s1_gm_q  <= gm_gnt;
         s1_oor_q <= win_oor;
         s2_vld_q <= s1_vld_q;
         s2_gm_q  <= s1_gm_q;
         s2_oor_q <= s1_oor_q;
         // Out-of-range reads never touched the RAM, so their code is substituted here.
         vid_valid_q <= s2_vld_q && !s2_gm_q;
         gm_rvalid_q <= s2_vld_q && s2_gm_q;
         if (s2_vld_q && !s2_gm_q) begin
            vid_code_q <= s2_oor_q ? OOR_CODE : ram_rdata;
         end
         if (s2_vld_q && s2_gm_q) begin
            gm_rdata_q <= s2_oor_q ? OOR_CODE : ram_rdata;
         end
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign vid_valid = vid_valid_q;
   assign vid_code  = vid_code_q;
   assign gm_rvalid = gm_rvalid_q;
   assign gm_rdata  = gm_rdata_q;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Bench for map_access_arbiter: directed scenarios then random traffic, all checked against
// a grant-order reference model (shadow tile map plus queues of expected RAM accesses and results).
module tb_map_access_arbiter;

   localparam int MAP_W = 28;
   localparam int MAP_H = 31;
   localparam int CELLS = MAP_W * MAP_H;

   logic       clk;
   logic       rst;
   logic       vid_req;
   logic [4:0] vid_tx, vid_ty;
   logic       vid_gnt, vid_valid;
   logic [3:0] vid_code;
   logic       gm_req, gm_we;
   logic [4:0] gm_tx, gm_ty;
   logic [3:0] gm_wdata;
   logic       gm_gnt, gm_rvalid;
   logic [3:0] gm_rdata;
   logic       ram_en, ram_we;
   logic [9:0] ram_addr;
   logic [3:0] ram_wdata;
   logic [3:0] ram_rdata;

   map_access_arbiter dut (
      .clk(clk), .rst(rst),
      .vid_req(vid_req), .vid_tx(vid_tx), .vid_ty(vid_ty),
      .vid_gnt(vid_gnt), .vid_valid(vid_valid), .vid_code(vid_code),
      .gm_req(gm_req), .gm_we(gm_we), .gm_tx(gm_tx), .gm_ty(gm_ty), .gm_wdata(gm_wdata),
      .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM behind the arbiter, loaded from init_img on the first edge.
   logic       preload;
   logic [3:0] init_img [0:1023];
   logic [3:0] tb_ram   [0:1023];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) tb_ram[i] <= init_img[i];
      end else if (ram_en) begin
         if (ram_we) tb_ram[ram_addr] <= ram_wdata;
         else        ram_rdata <= tb_ram[ram_addr];
      end
   end

   typedef struct { int due; bit gm; logic [3:0] code; } rd_t;
   typedef struct { int due; bit we; int addr; logic [3:0] wd; } acc_t;

   logic [3:0] shadow [0:CELLS-1];
   rd_t        rdq[$];
   acc_t       accq[$];
   int         wait_m;
   logic [3:0] exp_vcode, exp_gcode;
   bit         outputs_known;
   int         cyc;
   int         n_checks, n_errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, check everything mid-cycle, advance the model.
   task automatic step(input bit r, input bit vr, input logic [4:0] vx, input logic [4:0] vy,
                       input bit gr, input bit gw, input logic [4:0] gx, input logic [4:0] gy,
                       input logic [3:0] gd, output bit vg, output bit gg);
      bit         exp_en, exp_vv, exp_gv, gm_w, vid_w, w_we, oor;
      acc_t       a;
      rd_t        d;
      int         tx, ty, addr;
      logic [3:0] w_wd;
      @(posedge clk);
      #1;
      preload = 1'b0;
      rst = r; vid_req = vr; vid_tx = vx; vid_ty = vy;
      gm_req = gr; gm_we = gw; gm_tx = gx; gm_ty = gy; gm_wdata = gd;
      @(negedge clk);
      if (outputs_known) begin
         exp_en = 1'b0;
         a = '{due: 0, we: 1'b0, addr: 0, wd: 4'h0};
         if (accq.size() > 0 && accq[0].due == cyc) begin
            a = accq.pop_front();
            exp_en = 1'b1;
         end
         check("ram_en", ram_en, exp_en);
         check("ram_we", ram_we, exp_en && a.we);
         if (exp_en) check("ram_addr", ram_addr, a.addr);
         if (exp_en && a.we) check("ram_wdata", ram_wdata, a.wd);
         exp_vv = 1'b0;
         exp_gv = 1'b0;
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            d = rdq.pop_front();
            if (d.gm) begin exp_gv = 1'b1; exp_gcode = d.code; end
            else      begin exp_vv = 1'b1; exp_vcode = d.code; end
         end
         check("vid_valid", vid_valid, exp_vv);
         check("vid_code", vid_code, exp_vcode);
         check("gm_rvalid", gm_rvalid, exp_gv);
         check("gm_rdata", gm_rdata, exp_gcode);
      end
      gm_w  = !r && gr && (!vr || wait_m == 16);
      vid_w = !r && vr && !gm_w;
      check("vid_gnt", vid_gnt, vid_w);
      check("gm_gnt", gm_gnt, gm_w);
      vg = vid_gnt;
      gg = gm_gnt;
      if (gm_w || vid_w) begin
         tx   = gm_w ? int'(gx) : int'(vx);
         ty   = gm_w ? int'(gy) : int'(vy);
         w_we = gm_w && gw;
         w_wd = gd;
         oor  = (tx >= MAP_W) || (ty >= MAP_H);
         addr = ty * MAP_W + tx;
         if (w_we) begin
            if (!oor) begin
               shadow[addr] = w_wd;
               accq.push_back('{due: cyc + 1, we: 1'b1, addr: addr, wd: w_wd});
            end
         end else begin
            rdq.push_back('{due: cyc + 3, gm: gm_w, code: oor ? 4'hF : shadow[addr]});
            if (!oor) accq.push_back('{due: cyc + 1, we: 1'b0, addr: addr, wd: 4'h0});
         end
      end
      if (r || !gr || gm_w) wait_m = 0;
      else if (wait_m < 16) wait_m++;
      if (r) begin
         rdq.delete();
         accq.delete();
         exp_vcode = 4'h0;
         exp_gcode = 4'h0;
         outputs_known = 1'b1;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      bit vg, gg;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, vg, gg);
   endtask

   initial begin
      bit         vg, gg, vpend, gpend, gw;
      logic [4:0] vx, vy, gx, gy;
      logic [3:0] gd;
      int         vwins, vafter, gcyc;

      n_checks = 0; n_errors = 0; cyc = 0; wait_m = 0;
      outputs_known = 1'b0; exp_vcode = 4'h0; exp_gcode = 4'h0;
      preload = 1'b1; rst = 1'b1;
      vid_req = 1'b0; vid_tx = '0; vid_ty = '0;
      gm_req = 1'b0; gm_we = 1'b0; gm_tx = '0; gm_ty = '0; gm_wdata = '0;
      for (int i = 0; i < 1024; i++) init_img[i] = 4'($urandom_range(0, 15));
      init_img[3 * 28 + 5] = 4'h2;
      for (int i = 0; i < CELLS; i++) shadow[i] = init_img[i];

      // Reset with both requesters active: no grants, all outputs cleared.
      step(1, 1, 5, 3, 1, 0, 2, 2, 0, vg, gg);
      step(1, 1, 5, 3, 1, 1, 2, 2, 9, vg, gg);

      // Video read of (5,3) -> address 89, code 2 three cycles later.
      step(0, 1, 5, 3, 0, 0, 0, 0, 0, vg, gg);
      check("vid_read_gnt", vg, 1);
      idle(1);
      check("vid_read_addr", ram_addr, 89);
      idle(1);
      idle(1);
      check("vid_read_valid", vid_valid, 1);
      check("vid_read_code", vid_code, 4'h2);
      idle(2);

      // Contention: video streams while a game read waits for its forced turn.
      vwins = 0; vafter = 0; gcyc = -1; gpend = 1'b1;
      gx = 5'($urandom_range(0, 27)); gy = 5'($urandom_range(0, 30));
      for (int i = 0; i < 20; i++) begin
         vx = 5'($urandom_range(0, 27)); vy = 5'($urandom_range(0, 30));
         step(0, 1, vx, vy, gpend, 0, gx, gy, 0, vg, gg);
         if (gg) begin gcyc = i; gpend = 1'b0; end
         else if (vg && gcyc < 0) vwins++;
         else if (vg) vafter++;
      end
      check("cont_vid_first", vwins, 16);
      check("cont_gm_cycle", gcyc, 16);
      check("cont_vid_resume", vafter, 3);
      idle(4);

      // Game write of 7 to (0,0) immediately followed by a video read of (0,0).
      step(0, 0, 0, 0, 1, 1, 0, 0, 4'h7, vg, gg);
      check("wr_gnt", gg, 1);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, vg, gg);
      idle(3);
      check("wr_rd_code", vid_code, 4'h7);

      // Out-of-range read returns 0xF without touching RAM; out-of-range write is dropped.
      step(0, 0, 0, 0, 1, 0, 28, 0, 0, vg, gg);
      check("oor_rd_gnt", gg, 1);
      idle(3);
      check("oor_rd_code", gm_rdata, 4'hF);
      step(0, 0, 0, 0, 1, 1, 3, 31, 4'h5, vg, gg);
      check("oor_wr_gnt", gg, 1);
      idle(2);

      // Reset landing one cycle after a video grant kills the in-flight read.
      step(0, 1, 7, 7, 0, 0, 0, 0, 0, vg, gg);
      check("mid_rst_gnt", vg, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, vg, gg);
      idle(4);
      check("mid_rst_valid", vid_valid, 0);
      check("mid_rst_code", vid_code, 0);

      // Random traffic with hold-until-grant requesters.
      vpend = 1'b0; gpend = 1'b0; gw = 1'b0; gd = '0;
      vx = '0; vy = '0; gx = '0; gy = '0;
      for (int i = 0; i < 800; i++) begin
         if (!vpend && $urandom_range(0, 9) < 6) begin
            vpend = 1'b1;
            vx = 5'($urandom_range(0, 31)); vy = 5'($urandom_range(0, 31));
         end
         if (!gpend && $urandom_range(0, 9) < 5) begin
            gpend = 1'b1;
            gw = 1'($urandom_range(0, 1));
            gx = 5'($urandom_range(0, 31)); gy = 5'($urandom_range(0, 31));
            gd = 4'($urandom_range(0, 15));
         end
         step(0, vpend, vx, vy, gpend, gw, gx, gy, gd, vg, gg);
         if (vg) vpend = 1'b0;
         if (gg) gpend = 1'b0;
      end
      idle(5);
      check("drain_reads", rdq.size(), 0);
      check("drain_access", accq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
